sipo_deser: RTL and testbench
=============================

Name: sipo_deser

Overview:
- Serial-in, parallel-out deserializer. It is the receive end of the team's 4-bit PISO serial link.
- Collects WIDTH serial bits into one parallel word, then presents the word on a valid/ready output port.
- Holds one finished word while the next word shifts in. Applies backpressure on the serial side only when a second word would overwrite an undrained one.

Parameters:
- WIDTH, 4, parallel word width in bits (>= 2).
- MSB_FIRST, 1, 1 = first serial bit lands in p_data[WIDTH-1]; 0 = first bit lands in p_data[0].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  serial bit on s_in is valid this cycle.
- s_in  input  1  serial data bit.
- s_ready  output  1  deserializer accepts a bit this cycle; a bit transfers when s_valid && s_ready.
- p_data  output  WIDTH  assembled parallel word; stable while p_valid && !p_ready.
- p_valid  output  1  p_data holds an unconsumed word.
- p_ready  input  1  consumer takes p_data this cycle when p_valid && p_ready.

Behaviour:
- Reset (rst=1 at a rising edge):
  - bit counter = 0, shift register = 0, p_data = 0, p_valid = 0.
  - Reset has priority over all other inputs.
  - A partially collected word is discarded.
  - An unconsumed output word is dropped.
- Internal state:
  - shift register sr[WIDTH-1:0].
  - bit counter cnt, range 0..WIDTH-1, width $clog2(WIDTH).
  - output holding register (p_data/p_valid).
- Bit accept (s_valid && s_ready):
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], s_in}.
  - MSB_FIRST=0: sr <= {s_in, sr[WIDTH-1:1]}.
  - If cnt < WIDTH-1, cnt increments.
- Word complete (bit accepted while cnt == WIDTH-1):
  - cnt wraps to 0.
  - p_data <= fully shifted word, including the current s_in.
  - p_valid <= 1.
  - Latency: p_valid is high in the cycle after the edge that sampled the last bit.
- No accept (s_valid=0): sr and cnt hold. Gaps of any length between bits are legal.
- Output drain (p_valid && p_ready, no completion in the same cycle): p_valid <= 0. p_data holds its last value.
- Simultaneous drain and completion: the old word is consumed and the new word loaded on the same edge. p_valid stays 1 with no bubble.
- Backpressure:
  - s_ready = !(cnt == WIDTH-1 && p_valid && !p_ready). Combinational from p_ready, by design.
  - s_ready is 1 for bits 0..WIDTH-2 regardless of output state.
  - Words are never overwritten or lost.
- p_ready while p_valid=0 has no effect.
- Bit order must match the PISO: with MSB_FIRST=1 the word 4'b1010 is carried as serial 1,0,1,0.
- No state machine beyond cnt plus the p_valid flag. States are conceptually FILL (p_valid=0) and HOLD (p_valid=1, next word filling).

Decomposition:
- Shared package serial_pkg:
  - SER_WIDTH_DEFAULT = 4.
  - MSB_FIRST / LSB_FIRST bit-order localparams.
  - Also used by the PISO.
- Single module; no sub-module. The counter and shift register are too small to split.

Test Plan (WIDTH=4 unless noted):
- Basic, MSB_FIRST=1, p_ready=1: after reset, s_valid=1 with bits 1,0,1,0 on 4 consecutive edges -> p_data=4'b1010, p_valid=1 for exactly 1 cycle starting the cycle after the 4th edge.
- Continuous stream, p_ready=1: bits 1010 0101 0000 back-to-back -> p_valid pulses every 4 cycles with p_data 1010, 0101, 0000; s_ready is never 0.
- Backpressure, p_ready=0:
  - Stimulus: bits 1010 then 0101.
  - p_data=1010 and p_valid=1 throughout.
  - s_ready=0 while the 8th bit (1) is presented, and that bit is held.
  - Raise p_ready for 1 cycle: the 8th bit is accepted on the same edge, and p_data=0101 with p_valid=1 the next cycle.
- Gapped input: bits 1,1,0,1 with s_valid=0 for 3 cycles between each bit -> single word 4'b1101; no extra p_valid pulses.
- Reset mid-word: accept bits 1,1, assert rst 1 cycle, then send 0,1,0,1 -> p_data=4'b0101. Also assert rst while p_valid=1 -> p_valid=0, p_data=0 the next cycle.
- MSB_FIRST=0: bits 1,0,1,0 -> p_data=4'b0101.

Source files
------------

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared constants for the 4-bit PISO/SIPO serial link
package serial_pkg;
  localparam int SER_WIDTH_DEFAULT = 4;
  localparam bit SER_MSB_FIRST     = 1'b1;
  localparam bit SER_LSB_FIRST     = 1'b0;
endpackage

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-in parallel-out deserializer with one-word output holding register
module sipo_deser
  import serial_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = SER_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic             s_in,
  output logic             s_ready,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  input  logic             p_ready
);
  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_p_data;
  logic             r_p_valid;

  logic             w_last;
  logic             w_accept;
  logic             w_s_ready;
  logic [WIDTH-1:0] w_next_sr;

  // Only the final bit of a word can stall, and only while the held word is not being drained.
  assign w_last    = (r_cnt == LAST);
  assign w_s_ready = !(w_last && r_p_valid && !p_ready);
  assign w_accept  = s_valid && w_s_ready;

  always_comb begin
    w_next_sr = r_sr;
    if (MSB_FIRST) begin
      w_next_sr = {r_sr[WIDTH-2:0], s_in};
    end else begin
      w_next_sr = {s_in, r_sr[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_sr      <= '0;
      r_p_data  <= '0;
      r_p_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sr <= w_next_sr;
        if (w_last) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
      // Completion wins over drain so a same-edge drain+load leaves p_valid high.
      if (w_accept && w_last) begin
        r_p_data  <= w_next_sr;
        r_p_valid <= 1'b1;
      end else if (r_p_valid && p_ready) begin
        r_p_valid <= 1'b0;
      end
    end
  end

  assign s_ready = w_s_ready;
  assign p_data  = r_p_data;
  assign p_valid = r_p_valid;
endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - table-driven check of sipo_deser in both bit orders
module tb_sipo_deser;
  logic       clk = 1'b0;
  logic       rst, s_valid, s_in, p_ready;
  logic       s_ready_m, p_valid_m, s_ready_l, p_valid_l;
  logic [3:0] p_data_m, p_data_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_in(s_in), .s_ready(s_ready_m),
    .p_data(p_data_m), .p_valid(p_valid_m), .p_ready(p_ready));

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_in(s_in), .s_ready(s_ready_l),
    .p_data(p_data_l), .p_valid(p_valid_l), .p_ready(p_ready));

  typedef struct {
    logic       rst, sv, si, pr;
    bit         chk;
    logic       exp_sr, exp_pv;
    logic [3:0] exp_pd;
    bit         chk_lsb;
    logic [3:0] exp_lsb;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic r, input logic sv, input logic si, input logic pr,
                   input bit chk, input logic sr, input logic pv, input logic [3:0] pd,
                   input bit cl = 1'b0, input logic [3:0] lpd = 4'h0);
    vec_t t;
    t.rst = r; t.sv = sv; t.si = si; t.pr = pr; t.chk = chk;
    t.exp_sr = sr; t.exp_pv = pv; t.exp_pd = pd; t.chk_lsb = cl; t.exp_lsb = lpd;
    vecs.push_back(t);
  endtask

  task automatic check1(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic sv, input logic si, input logic pr);
    rst = r; s_valid = sv; s_in = si; p_ready = pr;
    @(posedge clk); #1;
  endtask

  initial begin
    int wait_cycles;
    rst = 1'b1; s_valid = 1'b0; s_in = 1'b0; p_ready = 1'b0;

    // reset, then basic 1010
    v(1,0,0,1, 0, 1,0,4'h0);
    v(0,0,0,1, 1, 1,0,4'h0, 1, 4'h0);
    v(0,1,1,1, 1, 1,0,4'h0);
    v(0,1,0,1, 1, 1,0,4'h0);
    v(0,1,1,1, 1, 1,0,4'h0);
    v(0,1,0,1, 1, 1,0,4'h0);
    v(0,0,0,1, 1, 1,1,4'hA, 1, 4'h5);
    v(0,0,0,1, 1, 1,0,4'hA);
    // continuous 1010 0101 0000
    v(0,1,1,1, 1, 1,0,4'hA);
    v(0,1,0,1, 1, 1,0,4'hA);
    v(0,1,1,1, 1, 1,0,4'hA);
    v(0,1,0,1, 1, 1,0,4'hA);
    v(0,1,0,1, 1, 1,1,4'hA);
    v(0,1,1,1, 1, 1,0,4'hA);
    v(0,1,0,1, 1, 1,0,4'hA);
    v(0,1,1,1, 1, 1,0,4'hA);
    v(0,1,0,1, 1, 1,1,4'h5, 1, 4'hA);
    v(0,1,0,1, 1, 1,0,4'h5);
    v(0,1,0,1, 1, 1,0,4'h5);
    v(0,1,0,1, 1, 1,0,4'h5);
    v(0,0,0,1, 1, 1,1,4'h0, 1, 4'h0);
    v(0,0,0,0, 1, 1,0,4'h0);
    // backpressure: 1010 then 0101 with p_ready low
    v(0,1,1,0, 1, 1,0,4'h0);
    v(0,1,0,0, 1, 1,0,4'h0);
    v(0,1,1,0, 1, 1,0,4'h0);
    v(0,1,0,0, 1, 1,0,4'h0);
    v(0,1,0,0, 1, 1,1,4'hA);
    v(0,1,1,0, 1, 1,1,4'hA);
    v(0,1,0,0, 1, 1,1,4'hA);
    v(0,1,1,0, 1, 0,1,4'hA);
    v(0,1,1,0, 1, 0,1,4'hA);
    v(0,1,1,1, 1, 1,1,4'hA, 1, 4'h5);
    v(0,0,0,0, 1, 1,1,4'h5, 1, 4'hA);
    v(0,0,0,1, 1, 1,1,4'h5);
    v(0,0,0,0, 1, 1,0,4'h5);
    // gapped 1,1,0,1
    v(0,1,1,1, 1, 1,0,4'h5);
    for (int i = 0; i < 3; i++) v(0,0,0,1, 1, 1,0,4'h5);
    v(0,1,1,1, 1, 1,0,4'h5);
    for (int i = 0; i < 3; i++) v(0,0,0,1, 1, 1,0,4'h5);
    v(0,1,0,1, 1, 1,0,4'h5);
    for (int i = 0; i < 3; i++) v(0,0,0,1, 1, 1,0,4'h5);
    v(0,1,1,1, 1, 1,0,4'h5);
    v(0,0,0,1, 1, 1,1,4'hD, 1, 4'hB);
    v(0,0,0,1, 1, 1,0,4'hD);
    v(0,0,0,1, 1, 1,0,4'hD);
    // reset mid-word, then 0101; reset while holding a word
    v(0,1,1,1, 1, 1,0,4'hD);
    v(0,1,1,1, 1, 1,0,4'hD);
    v(1,1,1,1, 1, 1,0,4'hD);
    v(0,1,0,1, 1, 1,0,4'h0, 1, 4'h0);
    v(0,1,1,1, 1, 1,0,4'h0);
    v(0,1,0,1, 1, 1,0,4'h0);
    v(0,1,1,1, 1, 1,0,4'h0);
    v(0,0,0,0, 1, 1,1,4'h5, 1, 4'hA);
    v(1,0,0,0, 1, 1,1,4'h5);
    v(0,0,0,1, 1, 1,0,4'h0, 1, 4'h0);

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; s_valid = vecs[i].sv; s_in = vecs[i].si; p_ready = vecs[i].pr;
      #1;
      if (vecs[i].chk) begin
        check1("s_ready_msb", i, {3'b0, s_ready_m}, {3'b0, vecs[i].exp_sr});
        check1("p_valid_msb", i, {3'b0, p_valid_m}, {3'b0, vecs[i].exp_pv});
        check1("p_data_msb",  i, p_data_m, vecs[i].exp_pd);
        check1("s_ready_lsb", i, {3'b0, s_ready_l}, {3'b0, vecs[i].exp_sr});
        check1("p_valid_lsb", i, {3'b0, p_valid_l}, {3'b0, vecs[i].exp_pv});
      end
      if (vecs[i].chk_lsb) check1("p_data_lsb", i, p_data_l, vecs[i].exp_lsb);
      @(posedge clk); #1;
    end

    // latency: word 1001 must be valid exactly one cycle after its last bit
    step(1,0,0,0);
    step(0,1,1,0);
    step(0,1,0,0);
    step(0,1,0,0);
    s_valid = 1'b1; s_in = 1'b1; #1;
    check1("pre_last_valid", -1, {3'b0, p_valid_m}, 4'h0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    wait_cycles = 0;
    while (p_valid_m !== 1'b1 && wait_cycles < 8) begin
      @(posedge clk); #1;
      wait_cycles++;
    end
    check1("latency", -1, wait_cycles[3:0], 4'h0);
    check1("lat_data_msb", -1, p_data_m, 4'h9);
    check1("lat_data_lsb", -1, p_data_l, 4'h9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
